ctrl_seq: RTL

Control sequencer for the 8-bit single-bus CPU: a 6-state one-hot ring counter (T1..T6) that fetches each instruction and decodes the 4-bit opcode from the instruction register into the per-cycle control strobes. It sits directly upstream of the program counter and drives its `pc_inc`, `load_pc`, `pc_oen` and `clk_en` inputs, plus the MAR, RAM, IR, A, B, ALU and output-register strobes. All strobes are Moore outputs of the current T-state and latched opcode; the datapath samples them on the next rising `clk`.

---
 rtl/ctrl_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// ctrl_seq -- control sequencer for the 8-bit single-bus CPU.
//
// A one-hot ring counter (T1..T6) fetches each instruction in T1..T3 and then
// decodes the IR opcode nibble into the per-cycle control strobes for T4..T6.
// HLT in T4 parks the sequencer in HALT; only clr_n low leaves HALT.
// All strobes are Moore outputs of the state register and the latched opcode.
// The datapath samples them on the next rising clk.
//
// Optional feature macro: CTRL_SEQ_SHORT_CYCLE_EN
//   When it is defined, JMP, OUT and NOP end after T4, LDA ends after T5,
//   and ADD and SUB still run to T6.
//   When it is undefined, every non-HLT instruction runs T1..T6.
//
// Ports:
//   clk          in   system clock, rising edge
//   clr_n        in   asynchronous active-low reset
//   run          in   1 = advance, 0 = stall in the current T-state (strobes forced 0)
//   ir_opcode    in   [3:0] opcode nibble from the IR (valid from T4)
//   pc_inc, load_pc, pc_oen, clk_en        out  program counter controls
//   mar_in, ram_oen, ir_in, ir_oen         out  MAR load, RAM drive, IR load, IR operand drive
//   a_in, a_oen, b_in, alu_oen, alu_sub, out_in  out  datapath strobes
//   tstate       out  [5:0] one-hot current T-state, bit 0 = T1 (0 in HALT)
//   halted       out  sticky halt flag
//   instr_done   out  high during the last T-state of each instruction
module ctrl_seq #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_JMP = 4'h3,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       run,
    input  logic [3:0] ir_opcode,
    output logic       pc_inc,
    output logic       load_pc,
    output logic       pc_oen,
    output logic       clk_en,
    output logic       mar_in,
    output logic       ram_oen,
    output logic       ir_in,
    output logic       ir_oen,
    output logic       a_in,
    output logic       a_oen,
    output logic       b_in,
    output logic       alu_oen,
    output logic       alu_sub,
    output logic       out_in,
    output logic [5:0] tstate,
    output logic       halted,
    output logic       instr_done
);

`ifdef CTRL_SEQ_SHORT_CYCLE_EN
    localparam bit SHORT_CYCLE = 1'b1;
`else
    localparam bit SHORT_CYCLE = 1'b0;
`endif

    // The state is one-hot. Bit 6 is HALT, so tstate is simply the low six bits.
    localparam logic [6:0] S_T1   = 7'b000_0001;
    localparam logic [6:0] S_T2   = 7'b000_0010;
    localparam logic [6:0] S_T3   = 7'b000_0100;
    localparam logic [6:0] S_T4   = 7'b000_1000;
    localparam logic [6:0] S_T5   = 7'b001_0000;
    localparam logic [6:0] S_T6   = 7'b010_0000;
    localparam logic [6:0] S_HALT = 7'b100_0000;

    // These are bit positions in the raw strobe vector.
    localparam int B_PC_INC  = 13;
    localparam int B_LOAD_PC = 12;
    localparam int B_PC_OEN  = 11;
    localparam int B_CLK_EN  = 10;
    localparam int B_MAR_IN  = 9;
    localparam int B_RAM_OEN = 8;
    localparam int B_IR_IN   = 7;
    localparam int B_IR_OEN  = 6;
    localparam int B_A_IN    = 5;
    localparam int B_A_OEN   = 4;
    localparam int B_B_IN    = 3;
    localparam int B_ALU_OEN = 2;
    localparam int B_ALU_SUB = 1;
    localparam int B_OUT_IN  = 0;

    logic [6:0]  state;
    logic [6:0]  state_nxt;
    logic [13:0] strb_raw;
    logic [13:0] strb;
    logic        is_lda, is_add, is_sub, is_jmp, is_out, is_hlt, is_nop;
    logic        last_state;
    logic        strb_en;

    assign is_lda = (ir_opcode == OP_LDA);
    assign is_add = (ir_opcode == OP_ADD);
    assign is_sub = (ir_opcode == OP_SUB);
    assign is_jmp = (ir_opcode == OP_JMP);
    assign is_out = (ir_opcode == OP_OUT);
    assign is_hlt = (ir_opcode == OP_HLT);
    assign is_nop = !(is_lda || is_add || is_sub || is_jmp || is_out || is_hlt);

    // This is the final T-state of the current instruction. The next edge with run returns to T1.
    always_comb begin
        last_state = 1'b0;
        case (state)
            S_T4:    last_state = SHORT_CYCLE && (is_jmp || is_out || is_nop);
            S_T5:    last_state = SHORT_CYCLE && is_lda;
            S_T6:    last_state = 1'b1;
            default: last_state = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (run) begin
            case (state)
                S_T1:    state_nxt = S_T2;
                S_T2:    state_nxt = S_T3;
                S_T3:    state_nxt = S_T4;
                S_T4:    state_nxt = is_hlt ? S_HALT : (last_state ? S_T1 : S_T5);
                S_T5:    state_nxt = last_state ? S_T1 : S_T6;
                S_T6:    state_nxt = S_T1;
                S_HALT:  state_nxt = S_HALT;
                default: state_nxt = S_T1;  // recover from any non-one-hot value
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= S_T1;
        else        state <= state_nxt;
    end

    // This is the raw strobe decode of the current T-state and opcode.
    always_comb begin
        strb_raw = '0;
        case (state)
            S_T1: begin
                strb_raw[B_PC_OEN] = 1'b1;
                strb_raw[B_MAR_IN] = 1'b1;
            end
            S_T2: begin
                strb_raw[B_PC_INC] = 1'b1;
                strb_raw[B_CLK_EN] = 1'b1;
            end
            S_T3: begin
                strb_raw[B_RAM_OEN] = 1'b1;
                strb_raw[B_IR_IN]   = 1'b1;
            end
            S_T4: begin
                if (is_lda || is_add || is_sub) begin
                    strb_raw[B_IR_OEN] = 1'b1;
                    strb_raw[B_MAR_IN] = 1'b1;
                end
                if (is_jmp) begin
                    // The gated PC clock must tick for the load to take effect.
                    strb_raw[B_IR_OEN]  = 1'b1;
                    strb_raw[B_LOAD_PC] = 1'b1;
                    strb_raw[B_CLK_EN]  = 1'b1;
                end
                if (is_out) begin
                    strb_raw[B_A_OEN]  = 1'b1;
                    strb_raw[B_OUT_IN] = 1'b1;
                end
            end
            S_T5: begin
                if (is_lda) begin
                    strb_raw[B_RAM_OEN] = 1'b1;
                    strb_raw[B_A_IN]    = 1'b1;
                end
                if (is_add || is_sub) begin
                    strb_raw[B_RAM_OEN] = 1'b1;
                    strb_raw[B_B_IN]    = 1'b1;
                    strb_raw[B_ALU_SUB] = is_sub;
                end
            end
            S_T6: begin
                if (is_add || is_sub) begin
                    strb_raw[B_ALU_OEN] = 1'b1;
                    strb_raw[B_A_IN]    = 1'b1;
                    strb_raw[B_ALU_SUB] = is_sub;
                end
            end
            default: strb_raw = '0;  // HALT drives nothing
        endcase
    end

    // The clr_n input itself gates the strobes. Reset parks the state in T1,
    // and the T1 fetch strobes must not reach the bus while reset is held.
    assign strb_en = clr_n && run;
    assign strb    = strb_en ? strb_raw : '0;

    assign pc_inc  = strb[B_PC_INC];
    assign load_pc = strb[B_LOAD_PC];
    assign pc_oen  = strb[B_PC_OEN];
    assign clk_en  = strb[B_CLK_EN];
    assign mar_in  = strb[B_MAR_IN];
    assign ram_oen = strb[B_RAM_OEN];
    assign ir_in   = strb[B_IR_IN];
    assign ir_oen  = strb[B_IR_OEN];
    assign a_in    = strb[B_A_IN];
    assign a_oen   = strb[B_A_OEN];
    assign b_in    = strb[B_B_IN];
    assign alu_oen = strb[B_ALU_OEN];
    assign alu_sub = strb[B_ALU_SUB];
    assign out_in  = strb[B_OUT_IN];

    assign tstate     = state[5:0];
    assign halted     = state[6];
    assign instr_done = clr_n && last_state;

endmodule
